// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   - Transfer size encodings used on the inst/data SRAM-like ports.
//   - Owner encodings for the transaction in flight.
//   - FSM state encodings (kept as plain localparams for legacy users).
//   - A request bundle type used to mux the winning port onto the RAM.
package sram_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // One port's request fields, bundled so the grant mux is a single select.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane write strobe generator.
//   size    in  2  transfer size (byte / half / word; 3 treated as word)
//   addr_lo in  2  low byte-address bits
//   wea     out 4  byte write strobes, bit i enables byte lane i
module sram_wstrb_gen
  import sram_arb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wea
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    wea = 4'b1111;
    case (size)
      SZ_BYTE: wea = 4'b0001 << addr_lo;
      // Halfword lanes come from addr[1] alone; a misaligned addr[0] is ignored.
      SZ_HALF: wea = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: wea = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port to one-port arbiter for a shared single-port block RAM.
// The instruction and data SRAM-like ports compete for the RAM with a fixed
// priority; at most one access is in flight, and a new access may issue in
// the same cycle the previous one responds, giving one access per cycle.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   inst_req/wr/size/addr/wdata   instruction-port request
//   inst_addr_ok             instruction request accepted this cycle
//   inst_data_ok/inst_rdata  instruction response (rdata 0 for writes)
//   data_*                   same set for the data port
//   ram_ena/wea/addra/dina   RAM request (wea = byte strobes)
//   ram_douta                RAM read data, one cycle after ram_ena
//
// Parameters:
//   RAM_AW     RAM word-address width; ram_addra = addr[RAM_AW+1:2]
//   DATA_PRIO  1: data port wins simultaneous requests, 0: inst port wins
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [31:0]       inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,

  output logic              ram_ena,
  output logic [3:0]        ram_wea,
  output logic [RAM_AW-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta
);

  logic [0:0] state;
  logic       owner;
  logic       was_read;

  sram_req_t  inst_q;
  sram_req_t  data_q;
  sram_req_t  win;

  logic       inst_win;
  logic       data_win;
  logic       issue;
  logic [3:0] wstrb;
  logic       resp;
  logic [31:0] resp_data;

  assign inst_q = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_q = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  // Grant. Issue is allowed in both states: in BUSY the RAM port is free
  // again because the in-flight access completes its read this cycle.
  // Fixed priority with no fairness: a held winning request starves the
  // other port by design.
  always_comb begin
    inst_win = 1'b0;
    data_win = 1'b0;
    if (!rst) begin
      if (inst_req && data_req) begin
        if (DATA_PRIO) data_win = 1'b1;
        else           inst_win = 1'b1;
      end else begin
        inst_win = inst_req;
        data_win = data_req;
      end
    end
  end

  assign issue = inst_win | data_win;
  assign win   = data_win ? data_q : inst_q;

  assign inst_addr_ok = inst_win;
  assign data_addr_ok = data_win;

  sram_wstrb_gen u_wstrb (
    .size    (win.size),
    .addr_lo (win.addr[1:0]),
    .wea     (wstrb)
  );

  // Upper address bits beyond the RAM are dropped, so addresses alias.
  assign ram_ena   = issue;
  assign ram_wea   = (issue && win.wr) ? wstrb : 4'b0000;
  assign ram_addra = win.addr[RAM_AW+1:2];
  assign ram_dina  = win.wdata;

  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, win.addr[31:RAM_AW+2]};

  // Response: the cycle after an issue the FSM is in BUSY and the RAM output
  // carries the read word. Reset suppresses a response that was in flight.
  assign resp      = (state == ST_BUSY) && !rst;
  assign resp_data = was_read ? ram_douta : 32'h0;

  assign inst_data_ok = resp && (owner == OWN_INST);
  assign data_data_ok = resp && (owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? resp_data : 32'h0;
  assign data_rdata   = data_data_ok ? resp_data : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_INST;
      was_read <= 1'b0;
    end else if (issue) begin
      state    <= ST_BUSY;
      owner    <= data_win ? OWN_DATA : OWN_INST;
      was_read <= !win.wr;
    end else begin
      state    <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter. Drivers push hand-computed RAM requests
// and responses into per-port queues; a negedge monitor pops and compares
// whenever the DUT issues to the RAM or presents data_ok.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addra;
    logic [3:0]    wea;
    logic [31:0]   din;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Main DUT (data priority)
  logic          inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]    inst_size = 0, data_size = 0;
  logic [31:0]   inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0]   inst_rdata, data_rdata;
  logic          ram_ena;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [31:0]   ram_douta = 0;

  sram_arbiter #(.RAM_AW(AW), .DATA_PRIO(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  // Second DUT (inst priority), only used for the starvation check
  logic          p0_inst_req = 0, p0_data_req = 0;
  logic          p0_inst_addr_ok, p0_inst_data_ok, p0_data_addr_ok, p0_data_data_ok;
  logic [31:0]   p0_inst_rdata, p0_data_rdata;
  logic          p0_ram_ena;
  logic [3:0]    p0_ram_wea;
  logic [AW-1:0] p0_ram_addra;
  logic [31:0]   p0_ram_dina;
  logic [31:0]   p0_ram_douta = 32'h0;
  logic          p0_wr = 1'b0;
  logic [1:0]    p0_size = SZ_WORD;
  logic [31:0]   p0_zero = 32'h0;

  sram_arbiter #(.RAM_AW(AW), .DATA_PRIO(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(p0_inst_req), .inst_wr(p0_wr), .inst_size(p0_size),
    .inst_addr(p0_zero), .inst_wdata(p0_zero),
    .inst_addr_ok(p0_inst_addr_ok), .inst_data_ok(p0_inst_data_ok), .inst_rdata(p0_inst_rdata),
    .data_req(p0_data_req), .data_wr(p0_wr), .data_size(p0_size),
    .data_addr(p0_zero), .data_wdata(p0_zero),
    .data_addr_ok(p0_data_addr_ok), .data_data_ok(p0_data_data_ok), .data_rdata(p0_data_rdata),
    .ram_ena(p0_ram_ena), .ram_wea(p0_ram_wea), .ram_addra(p0_ram_addra),
    .ram_dina(p0_ram_dina), .ram_douta(p0_ram_douta)
  );

  // Block RAM model: read-first, one-cycle read latency, byte writes.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_ena) begin
      ram_douta <= mem[ram_addra];
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
  end

  // Scoreboard queues, one set per port (0 = inst, 1 = data)
  iss_t        iss_q0[$], iss_q1[$];
  logic [31:0] rsp_q0[$], rsp_q1[$];
  int          due_q0[$], due_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    iss_t e;
    if (rst) begin
      check("rst_outputs",
            {26'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, ram_ena, |ram_wea},
            32'h0);
      check("rst_rdata", inst_rdata | data_rdata, 32'h0);
      due_q0.delete();
      due_q1.delete();
    end else begin
      if (ram_ena) begin
        if (inst_addr_ok == data_addr_ok) begin
          check("issue_one_addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
        end else if (inst_addr_ok ? iss_q0.size() == 0 : iss_q1.size() == 0) begin
          check("unexpected_issue", 32'h1, 32'h0);
        end else begin
          if (inst_addr_ok) begin
            e = iss_q0.pop_front();
            due_q0.push_back(cyc + 1);
          end else begin
            e = iss_q1.pop_front();
            due_q1.push_back(cyc + 1);
          end
          check("ram_addra", 32'(ram_addra), 32'(e.addra));
          check("ram_wea", 32'(ram_wea), 32'(e.wea));
          check("ram_dina", ram_dina, e.din);
        end
      end else if (inst_addr_ok || data_addr_ok || ram_wea != 4'b0) begin
        check("idle_no_addr_ok_wea", 32'h1, 32'h0);
      end
      if (inst_data_ok) begin
        if (rsp_q0.size() == 0 || due_q0.size() == 0) check("unexpected_inst_data_ok", 32'h1, 32'h0);
        else begin
          check("inst_rdata", inst_rdata, rsp_q0.pop_front());
          check("inst_latency", 32'(cyc), 32'(due_q0.pop_front()));
        end
      end else if (inst_rdata != 32'h0) check("inst_rdata_idle", inst_rdata, 32'h0);
      if (data_data_ok) begin
        if (rsp_q1.size() == 0 || due_q1.size() == 0) check("unexpected_data_data_ok", 32'h1, 32'h0);
        else begin
          check("data_rdata", data_rdata, rsp_q1.pop_front());
          check("data_latency", 32'(cyc), 32'(due_q1.pop_front()));
        end
      end else if (data_rdata != 32'h0) check("data_rdata_idle", data_rdata, 32'h0);
    end
  end

  // Drive one request on port p (0 inst, 1 data) until accepted; returns the
  // acceptance cycle. Called and returning just after a rising edge.
  task automatic do_port(input bit p, input bit wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [AW-1:0] exp_a, input logic [3:0] exp_wea,
                         input logic [31:0] exp_rd, input bit exp_rsp,
                         output int acc_cyc);
    bit ok = 1'b0;
    iss_t e;
    e = '{addra: exp_a, wea: exp_wea, din: wdata};
    if (p) begin
      iss_q1.push_back(e);
      if (exp_rsp) rsp_q1.push_back(exp_rd);
      data_wr = wr; data_size = sz; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
    end else begin
      iss_q0.push_back(e);
      if (exp_rsp) rsp_q0.push_back(exp_rd);
      inst_wr = wr; inst_size = sz; inst_addr = addr; inst_wdata = wdata; inst_req = 1'b1;
    end
    acc_cyc = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (p ? data_addr_ok : inst_addr_ok) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!ok) check(p ? "data_accept_timeout" : "inst_accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (p) data_req = 1'b0; else inst_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0, c1, c2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[0]    = 32'hA5A5_0000;
    mem[1]    = 32'h4444_4444;
    mem[4]    = 32'h1234_5678;
    mem[10'h40] = 32'h1122_3344;

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state",
          {26'h0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, ram_ena, |ram_wea},
          32'h0);
    @(posedge clk); #1;

    // Inst-only read
    do_port(0, 0, SZ_WORD, 32'h10, 32'h0, 10'd4, 4'b0000, 32'h1234_5678, 1, c0);
    idle(2);

    // Simultaneous inst read / data write, data wins
    fork
      do_port(0, 0, SZ_WORD, 32'h0, 32'h0, 10'd0, 4'b0000, 32'hA5A5_0000, 1, c0);
      do_port(1, 1, SZ_WORD, 32'h8, 32'hDEAD_BEEF, 10'd2, 4'b1111, 32'h0, 1, c1);
      begin
        @(negedge clk);
        check("prio_data_addr_ok", {31'h0, data_addr_ok}, 32'h1);
        check("prio_inst_held", {31'h0, inst_addr_ok}, 32'h0);
      end
    join
    check("prio_inst_one_later", 32'(c0 - c1), 32'h1);
    idle(2);

    // Back-to-back data reads
    do_port(1, 0, SZ_WORD, 32'h0, 32'h0, 10'd0, 4'b0000, 32'hA5A5_0000, 1, c0);
    do_port(1, 0, SZ_WORD, 32'h4, 32'h0, 10'd1, 4'b0000, 32'h4444_4444, 1, c1);
    do_port(1, 0, SZ_WORD, 32'h8, 32'h0, 10'd2, 4'b0000, 32'hDEAD_BEEF, 1, c2);
    check("b2b_gap1", 32'(c1 - c0), 32'h1);
    check("b2b_gap2", 32'(c2 - c1), 32'h1);
    idle(2);

    // Byte/half writes; data is lane-aligned, so only the strobed lanes land
    do_port(1, 1, SZ_BYTE, 32'h101, 32'h0000_00AA, 10'h40, 4'b0010, 32'h0, 1, c0);
    do_port(1, 1, SZ_HALF, 32'h102, 32'h0000_BB00, 10'h40, 4'b1100, 32'h0, 1, c0);
    do_port(1, 0, SZ_WORD, 32'h100, 32'h0, 10'h40, 4'b0000, 32'h0000_0044, 1, c0);
    do_port(1, 1, SZ_BYTE, 32'h101, 32'h0000_AA00, 10'h40, 4'b0010, 32'h0, 1, c0);
    do_port(1, 1, SZ_HALF, 32'h103, 32'hCCDD_0000, 10'h40, 4'b1100, 32'h0, 1, c0);
    do_port(1, 0, SZ_BYTE, 32'h100, 32'h0, 10'h40, 4'b0000, 32'hCCDD_AA44, 1, c0);
    // Size 3 acts as word; 0x1000 aliases to word 0
    do_port(1, 1, 2'd3, 32'h1000, 32'h0F0F_0F0F, 10'd0, 4'b1111, 32'h0, 1, c0);
    do_port(1, 1, SZ_BYTE, 32'h7, 32'h7700_0000, 10'd1, 4'b1000, 32'h0, 1, c0);
    do_port(0, 0, SZ_WORD, 32'h0, 32'h0, 10'd0, 4'b0000, 32'h0F0F_0F0F, 1, c0);
    do_port(0, 0, SZ_HALF, 32'h4, 32'h0, 10'd1, 4'b0000, 32'h7744_4444, 1, c0);
    idle(2);

    // Reset in the cycle after an accepted read: no response may follow
    do_port(0, 0, SZ_WORD, 32'h10, 32'h0, 10'd4, 4'b0000, 32'h0, 0, c0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    do_port(0, 0, SZ_WORD, 32'h10, 32'h0, 10'd4, 4'b0000, 32'h1234_5678, 1, c0);
    idle(3);

    // Inst priority instance: data port starved while both request
    p0_inst_req = 1'b1;
    p0_data_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("p0_inst_addr_ok", {31'h0, p0_inst_addr_ok}, 32'h1);
      check("p0_data_addr_ok", {31'h0, p0_data_addr_ok}, 32'h0);
    end
    @(posedge clk); #1;
    p0_inst_req = 1'b0;
    p0_data_req = 1'b0;
    idle(3);

    check("drain_iss", 32'(iss_q0.size() + iss_q1.size()), 32'h0);
    check("drain_rsp", 32'(rsp_q0.size() + rsp_q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
